// File: rtl/stream_mux_pkg.sv
// Shared types and sizes for the 8-to-1 packet stream multiplexer.
// Imported by the arbiter and the top level.
package stream_mux_pkg;

    localparam int CH_NUM    = 8;
    localparam int SEL_WIDTH = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin pick among eight requesters.
// Search starts at ptr+1 and wraps, so ptr itself has lowest priority.
module rr_arbiter_8
    import stream_mux_pkg::*;
(
    input  logic [CH_NUM-1:0]    req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic                 any_req,
    output logic [SEL_WIDTH-1:0] winner
);

    logic                 found;
    logic [SEL_WIDTH-1:0] idx;

    // first set request bit after ptr, wrapping modulo 8
    always_comb begin
        any_req = |req;
        winner  = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            idx = ptr + SEL_WIDTH'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_8.sv
// Eight-source packet stream mux: round-robin grant locked per packet,
// one registered output stage carrying the source channel index.
module stream_mux_8
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [CH_NUM*DATA_WIDTH-1:0] in_data_i,
    input  logic [CH_NUM-1:0]            in_valid_i,
    input  logic [CH_NUM-1:0]            in_last_i,
    output logic [CH_NUM-1:0]            in_ready_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic                         out_last_o,
    output logic [SEL_WIDTH-1:0]         out_sel_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i
);

    state_t                state;
    state_t                state_nxt;
    logic [SEL_WIDTH-1:0]  grant;
    logic [SEL_WIDTH-1:0]  ptr;
    logic [SEL_WIDTH-1:0]  winner;
    logic                  any_req;
    logic                  load_en;
    logic                  xfer;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter_8 u_arb (
        .req     (in_valid_i),
        .ptr     (ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    assign load_en   = !out_valid_o | out_ready_i;
    assign sel_valid = in_valid_i[grant];
    assign sel_last  = in_last_i[grant];
    assign sel_data  = in_data_i[grant*DATA_WIDTH +: DATA_WIDTH];

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, accept towards the granted source, beat transfer
    always_comb begin
        state_nxt  = state;
        in_ready_o = '0;
        xfer       = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                in_ready_o[grant] = load_en;
                xfer = load_en & sel_valid;
                if (xfer && sel_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // grant capture in IDLE, pointer moves to the channel just finished
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant <= '0;
            ptr   <= '1;
        end else begin
            if (state == IDLE && any_req) begin
                grant <= winner;
            end
            if (xfer && sel_last) begin
                ptr <= grant;
            end
        end
    end

    // output register: load on accept, drop valid once drained
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_sel_o   <= '0;
        end else if (xfer) begin
            out_valid_o <= 1'b1;
            out_data_o  <= sel_data;
            out_last_o  <= sel_last;
            out_sel_o   <= grant;
        end else if (load_en) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: doc/stream_mux_8.md
Name: stream_mux_8

Overview:
Eight-input to one-output packet stream multiplexer, the merging counterpart of the team's 1-to-8 demultiplexer. Eight valid/ready/last sources are arbitrated round-robin. The granted source is locked for a whole packet and forwarded through one registered output stage with its source index. It sits where per-channel streams recombine onto a single shared sink.

Parameters:
DATA_WIDTH, 8, width of each data beat in bits.

Ports:
clk_i  input  1  clock; all state changes on its rising edge.
rst_i  input  1  asynchronous, active-high reset.
in_data_i  input  8 x DATA_WIDTH  packed per-channel data; element n belongs to channel n.
in_valid_i  input  8  per-channel beat valid.
in_last_i  input  8  per-channel end-of-packet marker, qualified by valid.
in_ready_o  output  8  per-channel accept; at most one bit high at any time.
out_data_o  output  DATA_WIDTH  registered output beat.
out_last_o  output  1  registered end-of-packet marker.
out_sel_o  output  3  registered source channel index of the current output beat.
out_valid_o  output  1  output beat valid.
out_ready_i  input  1  sink accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_sel_o=0, in_ready_o=0.
  - State IDLE, grant=0, rr pointer ptr=7, so channel 0 has first priority.
- Handshakes:
  - Input beat on channel n transfers when in_valid_i[n] & in_ready_o[n].
  - Output beat transfers when out_valid_o & out_ready_i.
  - Sources must hold valid/data/last stable until accepted.
- load_en = !out_valid_o | out_ready_i. The output register is empty or being drained this cycle.
- State IDLE:
  - in_ready_o=0.
  - If any in_valid_i bit is set, the winner is the first set bit searching ptr+1, ptr+2 … ptr+8 (mod 8). grant<=winner, go LOCKED.
  - No valid bits: stay IDLE.
- State LOCKED:
  - in_ready_o[grant] = load_en; all other bits 0.
  - On input transfer: out_data_o<=in_data_i[grant], out_last_o<=in_last_i[grant], out_sel_o<=grant, out_valid_o<=1.
  - Transfer with in_last_i[grant]=1: ptr<=grant, go IDLE.
  - A granted channel with valid low stalls the mux; the lock is held and no other channel is served.
- No input transfer while load_en: out_valid_o<=0 after an output transfer; out_data_o/last/sel hold their values.
- Latency and throughput:
  - Beat valid at cycle 0 in IDLE → grant registered cycle 1 → accepted cycle 1 (if load_en) → out_valid_o cycle 2.
  - Within a packet: 1 beat/cycle with out_ready_i held high.
  - Exactly one idle arbitration cycle between packets.
- Simultaneous output drain and input accept in the same cycle: new beat replaces old, out_valid_o stays 1, no bubble.
- Backpressure: with out_ready_i=0 and out_valid_o=1, in_ready_o is all 0 and all output registers hold.
- Single-beat packet (last on the first beat) is legal. The block returns to IDLE after one accepted beat.
- Reset mid-packet: packet truncated, output cleared immediately. Sources are reset alongside; no recovery of partial packets.
- in_last_i of non-granted channels is ignored.

Decomposition:
- Package stream_mux_pkg:
  - CH_NUM=8 and SEL_WIDTH=3.
  - State enum state_t {IDLE, LOCKED}.
  - Function next_ptr is not needed: ptr is loaded directly from grant.
- Sub-module rr_arbiter_8: purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any_req, winner[2:0].
  - Reused by future N-input arbiters.
- Top: state register, grant/ptr registers, output register stage.

Test Plan:
- Reset release, in_valid_i=8'h01, in_last_i[0]=1, data0=8'hA5, out_ready_i=1 → in_ready_o=8'h01 at cycle 1; out_valid_o=1, out_data_o=8'hA5, out_sel_o=0, out_last_o=1 at cycle 2; in_ready_o=0 during reset.
- Channels 2, 5, 7 all requesting 2-beat packets continuously → output packet order 2, 5, 7, 2, 5 …; one IDLE cycle between packets; out_sel_o constant within each packet.
- Channel 3 sends 4-beat packet (data 1, 2, 3, 4) while channel 4 is valid → beats 1–4 all with out_sel_o=3 and no interleaving; channel 4's packet follows; out_last_o only on beat 4.
- out_ready_i=0 for 5 cycles mid-packet → out_data_o stable; in_ready_o=8'h00; no beat lost or duplicated when out_ready_i returns to 1 (scoreboard match).
- Granted channel 6 drops valid for 3 cycles mid-packet while channel 1 requests → no channel 1 beats emitted until channel 6 last accepted.
- rst_i asserted asynchronously between clock edges mid-packet → out_valid_o=0 and in_ready_o=0 immediately; after release, channel 0 wins first when all channels request.
